// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel coordinates, display enable, h/v sync and a
// frame-start strobe. Every output is registered one clock behind the counters,
// so all outputs stay aligned with each other.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 48,
  parameter int unsigned H_SYNC   = 112,
  parameter int unsigned H_BP     = 248,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 38,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1
) (
  input  logic        VGA_CLK,
  input  logic        rst_n,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        disp_en,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HMax       = 11'(H_TOTAL - 1);
  localparam logic [10:0] VMax       = 11'(V_TOTAL - 1);
  localparam logic [10:0] HActive    = 11'(H_ACTIVE);
  localparam logic [10:0] VActive    = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;

  logic        active, hs_act, vs_act;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        fs_q, fs_d;

  // Counter next state: h wraps every line, v steps only on the h wrap.
  always_comb begin
    h_wrap  = (h_cnt_q == HMax);
    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VMax) ? 11'd0 : v_cnt_q + 11'd1;
    end
  end

  // Region decode from the current counters; FP/SYNC/BP are implicit ranges.
  always_comb begin
    active = (h_cnt_q < HActive) && (v_cnt_q < VActive);
    hs_act = (h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd);
    vs_act = (v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd);
    x_d    = active ? h_cnt_q : 11'd0;
    y_d    = active ? v_cnt_q : 11'd0;
    de_d   = active;
    hs_d   = hs_act ? H_POL : ~H_POL;
    vs_d   = vs_act ? V_POL : ~V_POL;
    fs_d   = active && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);
  end

  // Counter registers.
  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= 11'd0;
      v_cnt_q <= 11'd0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Output registers, one clock behind the counters.
  always_ff @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= 11'd0;
      y_q  <= 11'd0;
      de_q <= 1'b0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= fs_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign disp_en     = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign vga_blank_n = de_q;
  // No sync-on-green.
  assign vga_sync_n  = 1'b0;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus two reduced geometries
// (one with inverted sync polarity), all checked every cycle against a model
// that derives the raster position from the clock count since reset release.
module tb_vga_timing_gen;

  logic VGA_CLK = 1'b0;
  logic rst_n   = 1'b1;

  always #5 VGA_CLK = ~VGA_CLK;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          k;  // clock edges since reset release

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  // Full-size instance, active-high syncs.
  logic [10:0] f_x, f_y;
  logic f_de, f_hs, f_vs, f_bn, f_sn, f_fs;
  vga_timing_gen u_full (
    .VGA_CLK(VGA_CLK), .rst_n(rst_n), .x(f_x), .y(f_y), .disp_en(f_de), .hsync(f_hs),
    .vsync(f_vs), .vga_blank_n(f_bn), .vga_sync_n(f_sn), .frame_start(f_fs)
  );

  // Small geometry A: 28 x 16, active-high syncs.
  logic [10:0] a_x, a_y;
  logic a_de, a_hs, a_vs, a_bn, a_sn, a_fs;
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(3), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_small_a (
    .VGA_CLK(VGA_CLK), .rst_n(rst_n), .x(a_x), .y(a_y), .disp_en(a_de), .hsync(a_hs),
    .vsync(a_vs), .vga_blank_n(a_bn), .vga_sync_n(a_sn), .frame_start(a_fs)
  );

  // Small geometry B: 21 x 12, active-low syncs.
  logic [10:0] b_x, b_y;
  logic b_de, b_hs, b_vs, b_bn, b_sn, b_fs;
  vga_timing_gen #(
    .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_small_b (
    .VGA_CLK(VGA_CLK), .rst_n(rst_n), .x(b_x), .y(b_y), .disp_en(b_de), .hsync(b_hs),
    .vsync(b_vs), .vga_blank_n(b_bn), .vga_sync_n(b_sn), .frame_start(b_fs)
  );

  always @(posedge VGA_CLK or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Model: after edge k the outputs show raster position k-1 of the frame.
  task automatic compare_dut(input string tag, input int kk,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic hpol, input logic vpol,
                             input logic [10:0] ox, input logic [10:0] oy, input logic ode,
                             input logic ohs, input logic ovs, input logic obn,
                             input logic osn, input logic ofs);
    int ht, vt, p, col, row;
    logic ede, ehs, evs, efs;
    int ex, ey;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (kk == 0) begin
      ex = 0; ey = 0; ede = 1'b0; ehs = ~hpol; evs = ~vpol; efs = 1'b0;
    end else begin
      p   = (kk - 1) % (ht * vt);
      col = p % ht;
      row = p / ht;
      ede = (col < ha) && (row < va);
      ex  = ede ? col : 0;
      ey  = ede ? row : 0;
      ehs = (col >= ha + hf && col < ha + hf + hs) ? hpol : ~hpol;
      evs = (row >= va + vf && row < va + vf + vs) ? vpol : ~vpol;
      efs = (col == 0) && (row == 0);
    end
    check_eq({tag, ".x"}, 32'(ox), 32'(ex));
    check_eq({tag, ".y"}, 32'(oy), 32'(ey));
    check_eq({tag, ".disp_en"}, 32'(ode), 32'(ede));
    check_eq({tag, ".hsync"}, 32'(ohs), 32'(ehs));
    check_eq({tag, ".vsync"}, 32'(ovs), 32'(evs));
    check_eq({tag, ".blank_n"}, 32'(obn), 32'(ede));
    check_eq({tag, ".sync_n"}, 32'(osn), 32'd0);
    check_eq({tag, ".frame_start"}, 32'(ofs), 32'(efs));
  endtask

  // Sample on the falling edge, away from the active edge.
  always @(negedge VGA_CLK) begin
    compare_dut("full", k, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1,
                f_x, f_y, f_de, f_hs, f_vs, f_bn, f_sn, f_fs);
    compare_dut("a", k, 16, 3, 4, 5, 10, 1, 3, 2, 1'b1, 1'b1,
                a_x, a_y, a_de, a_hs, a_vs, a_bn, a_sn, a_fs);
    compare_dut("b", k, 12, 2, 3, 4, 6, 1, 2, 3, 1'b0, 1'b0,
                b_x, b_y, b_de, b_hs, b_vs, b_bn, b_sn, b_fs);
  end

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) @(posedge VGA_CLK);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    wait_edges(3);
    #2 rst_n = 1'b1;
    // Long first run covers whole full-size lines including the hsync window.
    wait_edges(3600);
    // Random mid-frame resets, asserted and released between clock edges.
    for (int i = 0; i < 6; i++) begin
      #2 rst_n = 1'b0;
      wait_edges($urandom_range(1, 4));
      #2 rst_n = 1'b1;
      wait_edges($urandom_range(300, 2500));
    end
    wait_edges(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
